// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
//   state_e   : responder FSM states (idle, latency wait, response held)
//   LaneWidth : width of one byte lane in a data word
package mem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned LaneWidth = 8;

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH word storage. Contents are not reset.
// Ports:
//   clock   : write clock (rising edge)
//   word_we : write wdata to word idx
//   byte_we : write wdata[7:0] into byte lane 'lane' of word idx (word_we wins)
//   idx     : word index, shared by read and write
//   lane    : byte lane for byte writes (lane 0 = bits [7:0])
//   wdata   : write data
//   rdata   : combinational read of word idx
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             word_we,
  input  logic             byte_we,
  input  logic [IdxW-1:0]  idx,
  input  logic [2:0]       lane,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned NumLanes = WIDTH / LaneWidth;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (word_we) begin
      mem[idx] <= wdata;
    end else if (byte_we) begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        if (lane == 3'(l)) begin
          mem[idx][l*LaneWidth +: LaneWidth] <= wdata[LaneWidth-1:0];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
// Ports:
//   clock, reset             : rising-edge clock, async active-high reset
//   req_valid / req_ready    : request handshake (ready only while idle)
//   req_addr                 : byte address; [2:0] selects the lane for byte stores
//   req_wdata                : store data (byte store uses [7:0])
//   req_word_we, req_byte_we : full-word / single-byte store (word wins)
//   resp_valid / resp_ready  : response handshake
//   resp_rdata, resp_err     : word after any store, out-of-range flag
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             req_word_we,
  input  logic             req_byte_we,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned NumLanes = WIDTH / LaneWidth;
  localparam int unsigned CntW     = 4;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept;
  logic             out_of_range;
  logic [IdxW-1:0]  idx;
  logic [2:0]       lane;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] post_store_word;

  assign idx          = req_addr[3 +: IdxW];
  assign lane         = req_addr[2:0];
  assign out_of_range = |req_addr[63:3+IdxW];
  assign accept       = (state_q == StIdle) && req_valid;

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clock   (clock),
    .word_we (accept && !out_of_range && req_word_we),
    .byte_we (accept && !out_of_range && req_byte_we),
    .idx     (idx),
    .lane    (lane),
    .wdata   (req_wdata),
    .rdata   (rd_word)
  );

  // Word as it will look once this edge's store lands, so the response
  // reflects read-after-write without a second cycle through the array.
  always_comb begin
    post_store_word = rd_word;
    if (req_word_we) begin
      post_store_word = req_wdata;
    end else if (req_byte_we) begin
      for (int unsigned l = 0; l < NumLanes; l++) begin
        if (lane == 3'(l)) begin
          post_store_word[l*LaneWidth +: LaneWidth] = req_wdata[LaneWidth-1:0];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rdata_d = out_of_range ? '0 : post_store_word;
          err_d   = out_of_range;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // LATENCY=2 instance
  logic        v2 = 0, rdy2, ww2 = 0, bw2 = 0, rv2, rr2 = 0, er2;
  logic [63:0] a2 = '0, wd2 = '0, rd2;
  // LATENCY=1 instance
  logic        v1 = 0, rdy1, ww1 = 0, bw1 = 0, rv1, rr1 = 0, er1;
  logic [63:0] a1 = '0, wd1 = '0, rd1;

  mem_responder #(.WIDTH(64), .DEPTH(1024), .LATENCY(2)) dut2 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (v2),
    .req_ready   (rdy2),
    .req_addr    (a2),
    .req_wdata   (wd2),
    .req_word_we (ww2),
    .req_byte_we (bw2),
    .resp_valid  (rv2),
    .resp_ready  (rr2),
    .resp_rdata  (rd2),
    .resp_err    (er2)
  );

  mem_responder #(.WIDTH(64), .DEPTH(1024), .LATENCY(1)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (v1),
    .req_ready   (rdy1),
    .req_addr    (a1),
    .req_wdata   (wd1),
    .req_word_we (ww1),
    .req_byte_we (bw1),
    .resp_valid  (rv1),
    .resp_ready  (rr1),
    .resp_rdata  (rd1),
    .resp_err    (er1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] rd;
  logic        er;
  int          lat;

  logic [63:0] s_addr [5] = '{64'h0, 64'h8, 64'h0, 64'h8, 64'h8};
  logic [63:0] s_wd   [5] = '{64'hCAFE_F00D_0123_4567, 64'h0F0E_0D0C_0B0A_0908,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5A};
  logic        s_ww   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        s_bw   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [63:0] s_exp  [5] = '{64'hCAFE_F00D_0123_4567, 64'h0F0E_0D0C_0B0A_0908,
                              64'hCAFE_F00D_0123_4567, 64'h0F0E_0D0C_0B0A_0908,
                              64'h0F0E_0D0C_0B0A_095A};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction on the LATENCY=2 instance; lat counts cycles from
  // the acceptance edge to the first cycle with resp_valid high.
  task automatic txn2(input logic [63:0] addr, input logic [63:0] wdata, input logic wwe,
                      input logic bwe, output logic [63:0] rdata, output logic err,
                      output int latency);
    int n;
    n = 0;
    while (!rdy2 && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_before_req", rdy2, 1);
    a2 = addr; wd2 = wdata; ww2 = wwe; bw2 = bwe; v2 = 1;
    tick();
    v2 = 0; ww2 = 0; bw2 = 0;
    latency = 1;
    while (!rv2 && latency < 20) begin
      tick();
      latency++;
    end
    rdata = rd2;
    err = er2;
    rr2 = 1;
    tick();
    rr2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req_ready", rdy2, 1);
    check("rst_resp_valid", rv2, 0);
    check("rst_resp_rdata", rd2, 0);
    check("rst_resp_err", er2, 0);
    check("rst_l1_req_ready", rdy1, 1);
    reset = 0;
    tick();

    // Word store then read
    txn2(64'h10, 64'h1122_3344_5566_7788, 1, 0, rd, er, lat);
    check("wstore_latency", lat, 2);
    check("wstore_raw_rdata", rd, 64'h1122_3344_5566_7788);
    check("wstore_err", er, 0);
    txn2(64'h10, 64'h0, 0, 0, rd, er, lat);
    check("read10_latency", lat, 2);
    check("read10_rdata", rd, 64'h1122_3344_5566_7788);
    check("read10_err", er, 0);

    // Byte store into lane 3
    txn2(64'h13, 64'hAB, 0, 1, rd, er, lat);
    check("bstore_raw_rdata", rd, 64'h1122_3344_AB66_7788);
    txn2(64'h10, 64'h0, 0, 0, rd, er, lat);
    check("bstore_read_rdata", rd, 64'h1122_3344_AB66_7788);

    // Both enables: word store wins, low address bits ignored
    txn2(64'h1D, 64'h1111_2222_3333_4444, 1, 1, rd, er, lat);
    check("both_we_raw", rd, 64'h1111_2222_3333_4444);
    txn2(64'h18, 64'h0, 0, 0, rd, er, lat);
    check("both_we_read", rd, 64'h1111_2222_3333_4444);

    // Out of range: 0x2000 aliases word 0 if the range check is broken
    txn2(64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, rd, er, lat);
    txn2(64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, rd, er, lat);
    check("oor_store_err", er, 1);
    check("oor_store_rdata", rd, 0);
    txn2(64'h2000, 64'h0, 0, 0, rd, er, lat);
    check("oor_read_err", er, 1);
    check("oor_read_rdata", rd, 0);
    txn2(64'h8000_0000_0000_0010, 64'h0, 0, 0, rd, er, lat);
    check("oor_high_err", er, 1);
    txn2(64'h0, 64'h0, 0, 0, rd, er, lat);
    check("oor_no_corrupt", rd, 64'h0123_4567_89AB_CDEF);
    check("oor_no_corrupt_err", er, 0);

    // Backpressure: hold response 5 cycles while req_valid toggles with a store
    a2 = 64'h10; v2 = 1;
    tick();
    v2 = 0;
    tick();
    check("stall_resp_valid0", rv2, 1);
    for (int i = 0; i < 5; i++) begin
      v2 = ~v2; ww2 = 1; wd2 = 64'hDEAD_BEEF_DEAD_BEEF; a2 = 64'h10;
      tick();
      check("stall_resp_valid", rv2, 1);
      check("stall_rdata", rd2, 64'h1122_3344_AB66_7788);
      check("stall_err", er2, 0);
      check("stall_req_ready", rdy2, 0);
    end
    v2 = 0; ww2 = 0;
    rr2 = 1;
    tick();
    rr2 = 0;
    check("stall_consumed", rv2, 0);
    txn2(64'h10, 64'h0, 0, 0, rd, er, lat);
    check("stall_no_store", rd, 64'h1122_3344_AB66_7788);

    // Reset while in WAIT keeps the committed store
    a2 = 64'h8; wd2 = 64'hDEAD; ww2 = 1; v2 = 1;
    tick();
    v2 = 0; ww2 = 0;
    check("wait_resp_valid", rv2, 0);
    check("wait_req_ready", rdy2, 0);
    reset = 1;
    #1;
    check("midrst_resp_valid", rv2, 0);
    check("midrst_req_ready", rdy2, 1);
    check("midrst_rdata", rd2, 0);
    tick();
    reset = 0;
    tick();
    txn2(64'h8, 64'h0, 0, 0, rd, er, lat);
    check("midrst_store_kept", rd, 64'hDEAD);

    // LATENCY=1 back-to-back stream with req_valid and resp_ready held high
    rr1 = 1;
    for (int i = 0; i < 5; i++) begin
      a1 = s_addr[i]; wd1 = s_wd[i]; ww1 = s_ww[i]; bw1 = s_bw[i]; v1 = 1;
      tick();
      check("l1_resp_valid", rv1, 1);
      check("l1_req_ready_busy", rdy1, 0);
      check("l1_rdata", rd1, s_exp[i]);
      tick();
      check("l1_resp_done", rv1, 0);
      check("l1_req_ready_idle", rdy1, 1);
    end
    v1 = 0; ww1 = 0; bw1 = 0; rr1 = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: number of WIDTH-bit words; power of two.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance edge to resp_valid; legal range 1..15.
REQ-004 SHALL have port: clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port: req_ready  output  1  responder can accept a request this cycle.
REQ-008 SHALL have port: req_addr  input  64  byte address.
REQ-009 SHALL have port: req_wdata  input  WIDTH  store data; a byte store uses bits [7:0].
REQ-010 SHALL have port: req_word_we  input  1  full-word store.
REQ-011 SHALL have port: req_byte_we  input  1  single-byte store.
REQ-012 SHALL have port: resp_valid  output  1  response available.
REQ-013 SHALL have port: resp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port: resp_rdata  output  WIDTH  read data for the aligned word.
REQ-015 SHALL have port: resp_err  output  1  request was out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0 (one outstanding request).
REQ-018 A request SHALL be accepted on a rising edge where the FSM is in IDLE and req_valid=1.
REQ-019 The word index SHALL be req_addr[3+log2(DEPTH)-1:3], and req_addr[2:0] SHALL be ignored for word stores and reads.
REQ-020 Out of range SHALL mean req_addr[63:3+log2(DEPTH)] is nonzero; such a request SHALL perform no store, SHALL return resp_rdata=0 and SHALL return resp_err=1.
REQ-021 An in-range word store SHALL write req_wdata to the word at the acceptance edge.
REQ-022 An in-range byte store SHALL write req_wdata[7:0] into byte lane req_addr[2:0] (lane 0 = bits [7:0]) at the acceptance edge, and the other lanes SHALL be unchanged.
REQ-023 If req_word_we and req_byte_we are both 1, the word store SHALL take precedence.
REQ-024 resp_rdata SHALL be the word contents as they are after any store commits at the acceptance edge (read-after-write within one transaction); it SHALL be captured at that edge and held stable until the response is consumed.
REQ-025 On acceptance, if LATENCY=1 the FSM SHALL go to RESP; otherwise it SHALL go to WAIT with a down-counter loaded to LATENCY-2.
REQ-026 In WAIT, the FSM SHALL go to RESP when the counter is 0 and SHALL decrement the counter otherwise.
REQ-027 resp_valid SHALL be 1 only in RESP, and SHALL therefore first assert exactly LATENCY cycles after the acceptance edge.
REQ-028 In RESP with resp_ready=1, the response SHALL be consumed at that edge and the FSM SHALL go to IDLE; in RESP with resp_ready=0, the FSM SHALL hold, with resp_rdata and resp_err stable.
REQ-029 The minimum request-to-request spacing SHALL be LATENCY+1 cycles.
REQ-030 resp_ready outside RESP SHALL be ignored, and req_valid outside IDLE SHALL be ignored (no store, no state change).
REQ-031 Reads SHALL have no side effects.

Reset
REQ-032 While reset=1, the FSM SHALL be IDLE, the counter 0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=1.
REQ-033 Reset mid-transaction SHALL drop the pending response; a store already committed at its acceptance edge SHALL remain committed.
REQ-034 Reset SHALL NOT clear memory contents; contents before the first store are undefined, and the bench SHALL preload or write before reading.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (IDLE, WAIT, RESP) and the byte-lane width constant (8).
REQ-036 A single sub-module mem_array SHALL be used: DEPTH x WIDTH storage with a synchronous write port (word write or lane-masked byte write) and a combinational read port; the FSM, counter and range check SHALL live in the top level.

Verification
REQ-037 Scenario: with LATENCY=2, word store addr 0x10 data 0x1122334455667788, then read addr 0x10 -> resp_valid exactly 2 cycles after each acceptance; resp_rdata=0x1122334455667788; resp_err=0.
REQ-038 Scenario: after REQ-037, byte store addr 0x13 data 0xAB, then read addr 0x10 -> resp_rdata=0x11223344AB667788.
REQ-039 Scenario: read addr 0x2000 (DEPTH=1024) -> resp_err=1 and resp_rdata=0; a following read of addr 0x0 shows no corruption.
REQ-040 Scenario: hold resp_ready=0 for 5 cycles in RESP while toggling req_valid -> resp_valid, resp_rdata and resp_err stay stable, req_ready=0, and no extra store occurs.
REQ-041 Scenario: assert reset in WAIT after a word store to 0x8 of 0xDEAD -> resp_valid=0 and req_ready=1 immediately; a later read of 0x8 returns 0xDEAD.
REQ-042 Scenario: with LATENCY=1, back-to-back reads with resp_ready held at 1 -> a new acceptance every 2 cycles and resp_valid 1 cycle after each acceptance.
